uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- UART receiver plus receive FIFO on the 14.7456 MHz peripheral clock, directly downstream of the board RX pin, feeding received bytes to the core-side UART register block.
- Fixed format: 8N1, LSB first, 16x oversampling.
- Provides synchronisation, glitch-rejecting start detection, majority-vote sampling and framing/overrun flags.
- Output is a first-word-fall-through FIFO with a valid/ready interface.

Parameters:
- CLK_PER_TICK, 8, Clk cycles per 1/16 bit period (14.7456 MHz / (16*115200) = 8); legal range 1..65535.
- FIFO_DEPTH, 16, receive FIFO entries; power of two, at least 2.

Ports:
- Clk  input  1  peripheral clock (Clk_14_7456MHz domain).
- Rst_n  input  1  asynchronous active-low reset.
- RX  input  1  asynchronous serial input; idle high.
- rx_data  output  8  FIFO head byte; valid only when rx_valid=1.
- rx_valid  output  1  FIFO not empty.
- rx_ready  input  1  consumer pop; a pop occurs when rx_valid & rx_ready are both high.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: one clock (Clk); reset is asynchronous and active-low (Rst_n). While Rst_n=0:
  - synchroniser flops = 1; state = IDLE; tick and bit counters = 0; FIFO empty.
  - rx_valid=0, rx_data=0, frame_err=0, overrun=0, fifo_count=0, rx_busy=0.
- Reset mid-frame discards the partial byte and all FIFO contents.
- Input path: 2-FF synchroniser on RX; rxs = second-stage output. Sync latency is 2 Clk.
- Tick generator:
  - Counter 0..CLK_PER_TICK-1; tick pulses when the counter wraps.
  - Held at 0 in IDLE, so the phase restarts on each start edge.
- Sample phase: tcnt (4 bits) counts ticks inside a bit, 0..15, and wraps.
  - Samples taken at tcnt = 7, 8, 9; bit value = majority of the three.
  - Bit period ends on the tick where tcnt = 15.
- State machine (IDLE, START, DATA, STOP, WAIT_IDLE):
  - IDLE: rxs=0 → START with tcnt=0.
  - START: at the tick with tcnt=9, majority=1 (glitch) → IDLE with no flags; majority=0 → continue. At tcnt=15 → DATA with bit index 0.
  - DATA: the majority bit is shifted in LSB first at tcnt=9. At tcnt=15, bit index 7 → STOP; otherwise increment the index.
  - STOP: decision at tcnt=9 (mid-stop), no wait for the full stop bit, so back-to-back frames are caught.
    - Majority 1: push the byte → IDLE.
    - Majority 0: frame_err pulse, byte discarded → WAIT_IDLE.
  - WAIT_IDLE: remain until rxs=1, then → IDLE. A held-low break gives exactly one frame_err.
- FIFO:
  - First-word fall-through: rx_data shows the head entry combinationally from registered storage.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - Push and pop in the same cycle when not full and not empty: both occur, count unchanged.
  - Push when full with a same-cycle pop: push accepted, no overrun.
  - Push when full without a pop: byte dropped, overrun pulses in the push cycle, contents unchanged.
  - Pop when empty: ignored.
- Flag timing: frame_err and overrun are asserted the cycle after the decision tick and are never high for two consecutive cycles. Both may occur in the same frame only in the mutually exclusive ways above.

Decomposition:
- uart_pkg holds:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, STOP, WAIT_IDLE};
  - localparams OVERSAMPLE=16, SAMPLE_LO=7, SAMPLE_MID=8, SAMPLE_HI=9, BIT_LAST=15, DATA_BITS=8.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; ports Clk, Rst_n, push, din, pop, dout, empty, full, count) is instantiated once.
- The receiver FSM and tick generator stay in uart_rx_fifo.

Test Plan (CLK_PER_TICK=1, so one bit = 16 Clk):
- Single frame 0xA5 (start, 1,0,1,0,0,1,0,1 LSB first, stop) → after the mid-stop sample: rx_valid=1, rx_data=0xA5, fifo_count=1. Pulse rx_ready → rx_valid=0, fifo_count=0.
- RX low for 5 Clk then high → no push, no flags, rx_busy returns low. Then send 0x3C → rx_data=0x3C.
- Frame 0x55 with stop bit 0, then RX held low 100 Clk → exactly one frame_err pulse, fifo_count=0, state IDLE only after RX rises.
- 17 back-to-back frames 0x00..0x10 with rx_ready=0 → fifo_count=16, one overrun pulse on byte 0x10. Drain yields 0x00..0x0F in order.
- FIFO full, rx_ready=1 held through the push cycle of the next byte 0x77 → no overrun, and 0x77 is read after the other 15 entries.
- Rst_n asserted at data bit 4 of 0x81 with 2 bytes queued → all outputs 0 immediately. After release, 0xC3 is received cleanly, fifo_count=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned SAMPLE_LO  = 7;
  localparam int unsigned SAMPLE_MID = 8;
  localparam int unsigned SAMPLE_HI  = 9;
  localparam int unsigned BIT_LAST   = 15;
  localparam int unsigned DATA_BITS  = 8;

  // Two-out-of-three vote used for each bit decision.
  function automatic logic maj3(logic a, logic b, logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is still accepted when the head leaves this cycle.
  assign do_push = push & (~full | do_pop);
  // Head is forced to zero while empty so the output never shows stale data.
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge Clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver, 16x oversampled, feeding a FWFT receive FIFO.
module uart_rx_fifo import uart_pkg::*; #(
  parameter int unsigned CLK_PER_TICK = 8,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          RX,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          rx_busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);

  logic                 sync1_q, sync2_q, rxs;
  rx_state_t            state_q, state_d;
  logic [15:0]          div_q, div_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [2:0]           bidx_q, bidx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [1:0]           smp_q, smp_d;
  logic                 push_q, push_d;
  logic                 frame_err_q, frame_err_d;
  logic                 tick, maj;
  logic                 fifo_empty, fifo_full;

  assign rxs = sync2_q;
  assign tick = (state_q != IDLE) && (div_q == 16'(CLK_PER_TICK - 1));
  // Samples at 7 and 8 are stored; the third vote is the live sample at 9.
  assign maj = maj3(smp_q[1], smp_q[0], rxs);

  // Two-flop synchroniser, idles high.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= RX;
      sync2_q <= sync1_q;
    end
  end

  // Receiver next-state: tick divider, oversample phase, bit framing.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    tcnt_d      = tcnt_q;
    bidx_d      = bidx_q;
    shreg_d     = shreg_q;
    smp_d       = smp_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;

    if (state_q == IDLE || tick) div_d = '0;
    else                         div_d = div_q + 16'd1;

    if (tick) begin
      tcnt_d = tcnt_q + TW'(1);
      if (tcnt_q == TW'(SAMPLE_LO))  smp_d[1] = rxs;
      if (tcnt_q == TW'(SAMPLE_MID)) smp_d[0] = rxs;
    end

    unique case (state_q)
      IDLE: begin
        // Phase restarts from zero on every start edge.
        tcnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (tick && tcnt_q == TW'(SAMPLE_HI) && maj) begin
          state_d = IDLE;
        end else if (tick && tcnt_q == TW'(BIT_LAST)) begin
          state_d = DATA;
          bidx_d  = '0;
        end
      end
      DATA: begin
        if (tick && tcnt_q == TW'(SAMPLE_HI)) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
        if (tick && tcnt_q == TW'(BIT_LAST)) begin
          if (bidx_q == 3'(DATA_BITS - 1)) state_d = STOP;
          else                             bidx_d  = bidx_q + 3'd1;
        end
      end
      STOP: begin
        // Decide mid-stop so a start bit right after the stop bit is not missed.
        if (tick && tcnt_q == TW'(SAMPLE_HI)) begin
          if (maj) begin
            push_d  = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low break stays here so it yields a single frame error.
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      tcnt_q      <= '0;
      bidx_q      <= '0;
      shreg_q     <= '0;
      smp_q       <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      tcnt_q      <= tcnt_d;
      bidx_q      <= bidx_d;
      shreg_q     <= shreg_d;
      smp_q       <= smp_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
    end
  end

  // shreg_q is stable while push_q is high: it only shifts in DATA.
  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .push  (push_q),
    .din   (shreg_q),
    .pop   (rx_ready),
    .dout  (rx_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign rx_valid  = ~fifo_empty;
  assign frame_err = frame_err_q;
  // A same-cycle pop frees the slot, so only a stalled consumer causes a drop.
  assign overrun   = push_q & fifo_full & ~rx_ready;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo with CLK_PER_TICK=1 (16 Clk per bit).
module tb_uart_rx_fifo;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       RX = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, rx_busy;
  logic [4:0] fifo_count;

  int n_tests = 0;
  int n_fail  = 0;
  int fe_cnt  = 0;
  int ov_cnt  = 0;
  int consec  = 0;
  logic fe_prev = 1'b0;
  logic ov_prev = 1'b0;

  logic [7:0] model_q[$];

  uart_rx_fifo #(
    .CLK_PER_TICK (1),
    .FIFO_DEPTH   (16)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .RX         (RX),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .fifo_count (fifo_count),
    .rx_busy    (rx_busy)
  );

  always #5 Clk = ~Clk;

  // Pulse monitor: counts flag pulses and back-to-back highs.
  always @(negedge Clk) begin
    if (Rst_n) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if ((frame_err && fe_prev) || (overrun && ov_prev)) consec++;
    end
    fe_prev = frame_err;
    ov_prev = overrun;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Drives ncyc clocks of a frame; rx_ready is high only during cycle rdy_cyc.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int rdy_cyc,
                            input int ncyc);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      RX = fr[cyc / 16];
      rx_ready = (cyc == rdy_cyc);
      step(1);
    end
    rx_ready = 1'b0;
  endtask

  task automatic pop_one(output logic [7:0] d);
    @(negedge Clk);
    d = rx_data;
    rx_ready = 1'b1;
    @(posedge Clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0b want 0", rx_valid); end
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_data got %02h want 00", rx_data); end
    n_tests++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", fifo_count); end
    n_tests++; if ({frame_err, overrun, rx_busy} !== 3'b000) begin
      n_fail++; $display("FAIL rst_flags got %03b want 000", {frame_err, overrun, rx_busy});
    end
    step(2);
    Rst_n = 1'b1;
    step(3);
  endtask

  task automatic test_single();
    logic [7:0] d;
    send_frame(8'hA5, 1'b1, -1, 160);
    n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL a5_valid got %0b want 1", rx_valid); end
    n_tests++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL a5_data got %02h want a5", rx_data); end
    n_tests++; if (fifo_count !== 5'd1) begin n_fail++; $display("FAIL a5_count got %0d want 1", fifo_count); end
    pop_one(d);
    #1;
    n_tests++; if (rx_valid !== 1'b0 || fifo_count !== 5'd0) begin
      n_fail++; $display("FAIL a5_pop got valid=%0b count=%0d want 0/0", rx_valid, fifo_count);
    end
  endtask

  task automatic test_glitch();
    int fe0, ov0;
    logic [7:0] d;
    fe0 = fe_cnt; ov0 = ov_cnt;
    RX = 1'b0; step(5);
    RX = 1'b1; step(40);
    n_tests++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy got %0b want 0", rx_busy); end
    n_tests++; if (fifo_count !== 5'd0 || fe_cnt != fe0 || ov_cnt != ov0) begin
      n_fail++; $display("FAIL glitch_quiet got count=%0d fe=%0d ov=%0d want 0/0/0",
                         fifo_count, fe_cnt - fe0, ov_cnt - ov0);
    end
    send_frame(8'h3C, 1'b1, -1, 160);
    n_tests++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL glitch_3c got %02h want 3c", rx_data); end
    pop_one(d);
  endtask

  task automatic test_break();
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, -1, 160);
    step(100);
    n_tests++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL break_busy got %0b want 1", rx_busy); end
    RX = 1'b1;
    step(4);
    n_tests++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL break_idle got %0b want 0", rx_busy); end
    n_tests++; if (fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL break_fe got %0d want 1", fe_cnt - fe0); end
    n_tests++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL break_count got %0d want 0", fifo_count); end
  endtask

  task automatic test_overrun();
    int ov0, ov_exp;
    logic [7:0] d, e;
    ov0 = ov_cnt; ov_exp = 0;
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b1, -1, 160);
      if (model_q.size() < 16) model_q.push_back(8'(i));
      else ov_exp++;
      if (i == 15) begin
        n_tests++; if (ov_cnt != ov0) begin n_fail++; $display("FAIL ovr_early got %0d want 0", ov_cnt - ov0); end
      end
    end
    n_tests++; if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL ovr_count got %0d want 16", fifo_count); end
    n_tests++; if (ov_cnt - ov0 != ov_exp) begin n_fail++; $display("FAIL ovr_pulse got %0d want %0d", ov_cnt - ov0, ov_exp); end
    while (model_q.size() > 0) begin
      e = model_q.pop_front();
      pop_one(d);
      n_tests++; if (d !== e) begin n_fail++; $display("FAIL ovr_drain got %02h want %02h", d, e); end
    end
    #1;
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_empty got %0b want 0", rx_valid); end
  endtask

  task automatic test_full_pop();
    int ov0;
    logic [7:0] d, e;
    ov0 = ov_cnt;
    for (int i = 0; i < 16; i++) begin
      send_frame(8'h80 + 8'(i), 1'b1, -1, 160);
      model_q.push_back(8'h80 + 8'(i));
    end
    // Push cycle of a frame is 157 Clk after its start edge is driven.
    send_frame(8'h77, 1'b1, 157, 160);
    void'(model_q.pop_front());
    model_q.push_back(8'h77);
    n_tests++; if (ov_cnt != ov0) begin n_fail++; $display("FAIL fullpop_ovr got %0d want 0", ov_cnt - ov0); end
    n_tests++; if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL fullpop_count got %0d want 16", fifo_count); end
    while (model_q.size() > 0) begin
      e = model_q.pop_front();
      pop_one(d);
      n_tests++; if (d !== e) begin n_fail++; $display("FAIL fullpop_drain got %02h want %02h", d, e); end
    end
  endtask

  task automatic test_random();
    int fe0, ov0, fe_exp, ov_exp, n;
    logic [7:0] b, d, e;
    logic bad;
    fe0 = fe_cnt; ov0 = ov_cnt; fe_exp = 0; ov_exp = 0;
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 4) == 0);
      send_frame(b, ~bad, -1, 160);
      if (bad) fe_exp++;
      else if (model_q.size() < 16) model_q.push_back(b);
      else ov_exp++;
      RX = 1'b1;
      step($urandom_range(4, 20));
      if ($urandom_range(0, 2) == 0) begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
          if (model_q.size() > 0) begin
            e = model_q.pop_front();
            pop_one(d);
            n_tests++; if (d !== e) begin n_fail++; $display("FAIL rand_pop got %02h want %02h", d, e); end
          end
        end
      end
    end
    n_tests++; if (fifo_count !== 5'(model_q.size())) begin
      n_fail++; $display("FAIL rand_count got %0d want %0d", fifo_count, model_q.size());
    end
    n_tests++; if (fe_cnt - fe0 != fe_exp) begin n_fail++; $display("FAIL rand_fe got %0d want %0d", fe_cnt - fe0, fe_exp); end
    n_tests++; if (ov_cnt - ov0 != ov_exp) begin n_fail++; $display("FAIL rand_ovr got %0d want %0d", ov_cnt - ov0, ov_exp); end
    while (model_q.size() > 0) begin
      e = model_q.pop_front();
      pop_one(d);
      n_tests++; if (d !== e) begin n_fail++; $display("FAIL rand_drain got %02h want %02h", d, e); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    send_frame(8'h11, 1'b1, -1, 160);
    send_frame(8'h22, 1'b1, -1, 160);
    n_tests++; if (fifo_count !== 5'd2) begin n_fail++; $display("FAIL mrst_pre got %0d want 2", fifo_count); end
    // Stop part-way through data bit 4 of 0x81.
    send_frame(8'h81, 1'b1, -1, 88);
    Rst_n = 1'b0;
    #1;
    n_tests++; if ({rx_valid, frame_err, overrun, rx_busy} !== 4'b0000 || rx_data !== 8'h00 ||
                   fifo_count !== 5'd0) begin
      n_fail++; $display("FAIL mrst_out got v/fe/ov/busy=%04b data=%02h count=%0d want 0",
                         {rx_valid, frame_err, overrun, rx_busy}, rx_data, fifo_count);
    end
    model_q.delete();
    RX = 1'b1;
    step(3);
    Rst_n = 1'b1;
    step(3);
    send_frame(8'hC3, 1'b1, -1, 160);
    n_tests++; if (fifo_count !== 5'd1 || rx_data !== 8'hC3) begin
      n_fail++; $display("FAIL mrst_c3 got count=%0d data=%02h want 1/c3", fifo_count, rx_data);
    end
    pop_one(d);
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_break();
    test_overrun();
    test_full_pop();
    test_random();
    test_reset_midframe();
    n_tests++; if (consec != 0) begin n_fail++; $display("FAIL flag_consec got %0d want 0", consec); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
